fir_filter: RTL and testbench
=============================

// Module: fir_filter
// PURPOSE
//   Direct-form transposed-free 3-tap FIR filter on a signed 3-bit sample stream.
//   One new sample is accepted every sys_clk cycle.
//   Produces a registered, saturated signed 7-bit output one cycle after sampling.
//   Leaf DSP block; drives downstream logic directly, with no handshake (always-valid stream).
// PARAMETERS
//   DATA_W   3          input sample width, two's complement
//   OUT_W    7          output width, two's complement
//   COEF_W   4          coefficient width, two's complement
//   N_TAPS   3          number of taps (delay line length = N_TAPS-1)
//   COEFS    {1,2,1}    tap coefficients h0..h(N_TAPS-1); h0 multiplies the newest sample
// PORTS
//   sys_clk    in   1        single clock, all state on rising edge
//   sys_rst_n  in   1        asynchronous, active-low reset
//   Xin        in   DATA_W   signed input sample x[n], sampled every rising edge
//   Yout       out  OUT_W    signed filtered output y[n], registered
// BEHAVIOUR
//   - Reset (sys_rst_n=0, async assert): delay line d1..d(N_TAPS-1) <= 0; Yout <= 0 immediately.
//     Release is synchronised by usage only; the first edge with sys_rst_n=1 samples Xin normally.
//   - Each rising edge, when not in reset:
//       acc  = h0*Xin + h1*d1 + h2*d2   (full precision, signed)
//       Yout <= sat(acc, OUT_W);  d1 <= Xin;  d2 <= d1
//   - Latency: a sample present at edge k contributes h0*x to Yout from edge k onward (visible after edge k);
//     a single impulse produces Yout = h0, h1, h2, then 0 on consecutive edges.
//   - Accumulator width: DATA_W + COEF_W + clog2(N_TAPS) bits; no intermediate truncation.
//   - Saturation: acc > 2^(OUT_W-1)-1 -> +63; acc < -2^(OUT_W-1) -> -64 (defaults).
//     Default COEFS never saturate (|acc| <= 16).
//   - All arithmetic is signed; Xin = 3'b100 is -4, not 4.
//   - Reset mid-stream clears history; post-reset output depends only on post-reset samples.
//   - No enable: the filter advances on every edge; a constant input x yields steady-state Yout = x*sum(COEFS).
// STRUCTURE
//   - Package fir_pkg: default widths, N_TAPS, and a coefficient array typedef
//     (logic signed [COEF_W-1:0] coef_t [N_TAPS]), plus the default COEFS constant.
//   - Sub-module fir_sat: combinational signed saturation from IN_W to OUT_W.
//   - Top: generate-loop delay line, multiply-accumulate tree, fir_sat, output register.
// TESTING  (clock 10 ns; inputs change mid-cycle; default parameters)
//   - Reset: hold sys_rst_n=0 with Xin=3 -> Yout=0 and stays 0;
//     asserting reset mid-stream forces Yout=0 without waiting for a clock edge.
//   - Impulse: Xin=1 for one edge, then 0 -> Yout = 1, 2, 1, 0, 0.
//   - Ramp: Xin = 1,2,3,-4,-3,-2,-1,0,0,0 on successive edges
//     -> Yout = 1,4,8,4,-8,-12,-8,-4,-1,0.
//   - Step extremes: Xin=3 held -> Yout settles at 12; Xin=-4 held -> Yout settles at -16.
//   - Saturation (override COEFS={7,7,7}): Xin=-4 held -> Yout = -28, -56, -64 (clamped);
//     Xin=3 held -> Yout reaches 63 (clamped from 63; exact).
//   - Reset mid-operation: after a ramp, pulse reset, then apply an impulse -> response exactly 1,2,1,0,
//     with no residue from earlier samples.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : default widths, tap count and coefficient set for fir_filter
// Revision: 1.0
// ============================================================================
package fir_pkg;

  localparam int DEF_DATA_W = 3;
  localparam int DEF_OUT_W  = 7;
  localparam int DEF_COEF_W = 4;
  localparam int DEF_N_TAPS = 3;

  typedef logic signed [DEF_COEF_W-1:0] coef_t [DEF_N_TAPS];

  // h0 multiplies the newest sample
  localparam coef_t DEF_COEFS = '{4'sd1, 4'sd2, 4'sd1};

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_sat.sv
`default_nettype none
// ============================================================================
// fir_sat : combinational signed saturation from IN_W bits down to OUT_W bits
// Revision: 1.0
// ============================================================================
module fir_sat #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 7
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] C_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] C_MIN = IN_W'(-(2 ** (OUT_W - 1)));

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > C_MAX) begin
      dout = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (din < C_MIN) begin
      dout = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

endmodule : fir_sat
`default_nettype wire

// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
// fir_filter : N-tap direct-form FIR, full-precision MAC, saturated registered output
// Revision: 1.0
// ============================================================================
module fir_filter
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int N_TAPS = DEF_N_TAPS,
  parameter logic signed [COEF_W-1:0] COEFS [N_TAPS] = DEF_COEFS
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic signed [DATA_W-1:0] Xin,
  output logic signed [OUT_W-1:0]  Yout
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(N_TAPS);

  logic signed [DATA_W-1:0] dly_d  [N_TAPS-1];
  logic signed [DATA_W-1:0] dly_q  [N_TAPS-1];
  logic signed [DATA_W-1:0] tap    [N_TAPS];
  logic signed [ACC_W-1:0]  x_ext  [N_TAPS];
  logic signed [ACC_W-1:0]  c_ext  [N_TAPS];
  logic signed [ACC_W-1:0]  prod   [N_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  yout_d;
  logic signed [OUT_W-1:0]  yout_q;

  assign tap[0] = Xin;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS - 1; gi++) begin : g_dly
      assign dly_d[gi]   = tap[gi];
      assign tap[gi + 1] = dly_q[gi];
    end

    // Operands are sign-extended to the accumulator width so no product is truncated
    for (gi = 0; gi < N_TAPS; gi++) begin : g_mac
      assign x_ext[gi] = {{(ACC_W - DATA_W){tap[gi][DATA_W-1]}}, tap[gi]};
      assign c_ext[gi] = {{(ACC_W - COEF_W){COEFS[gi][COEF_W-1]}}, COEFS[gi]};
      assign prod[gi]  = x_ext[gi] * c_ext[gi];
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      acc = acc + prod[i];
    end
  end

  fir_sat #(
    .IN_W (ACC_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .din (acc),
    .dout(yout_d)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_TAPS - 1; i++) begin
        dly_q[i] <= '0;
      end
      yout_q <= '0;
    end else begin
      for (int i = 0; i < N_TAPS - 1; i++) begin
        dly_q[i] <= dly_d[i];
      end
      yout_q <= yout_d;
    end
  end

  assign Yout = yout_q;

endmodule : fir_filter
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
// tb_fir_filter : directed stimulus for fir_filter, default and {7,7,7} coefficient sets
// Revision: 1.0
// ============================================================================
module tb_fir_filter;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [2:0] xin   = 3'sd3;
  logic signed [6:0] y_def;
  logic signed [6:0] y_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_filter dut_def (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .Xin      (xin),
    .Yout     (y_def)
  );

  fir_filter #(
    .COEFS('{4'sd7, 4'sd7, 4'sd7})
  ) dut_sat (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .Xin      (xin),
    .Yout     (y_sat)
  );

  // Model: y[n] = clamp(sum h[k]*x[n-k]) over samples taken since the last reset
  int hist [3] = '{0, 0, 0};
  int exp_def = 0;
  int exp_sat = 0;

  function automatic int clamp(input int a);
    if (a > 63)  return 63;
    if (a < -64) return -64;
    return a;
  endfunction

  function automatic int conv(input int h0, input int h1, input int h2, input int s0, input int s1, input int s2);
    return clamp(h0 * s0 + h1 * s1 + h2 * s2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = '{0, 0, 0};
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(xin);
    end
    exp_def = conv(1, 2, 1, hist[0], hist[1], hist[2]);
    exp_sat = conv(7, 7, 7, hist[0], hist[1], hist[2]);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    check("model_def", int'(y_def), exp_def);
    check("model_sat", int'(y_sat), exp_sat);
  end

  task automatic step(input int x, input int e_def, input int e_sat);
    @(negedge clk);
    xin = 3'(x);
    @(posedge clk);
    #3;
    check("lit_def", int'(y_def), e_def);
    check("lit_sat", int'(y_sat), e_sat);
  endtask

  // Asserted mid-cycle; output must clear before any clock edge arrives
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("async_rst_def", int'(y_def), 0);
    check("async_rst_sat", int'(y_sat), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  int rx [10] = '{1, 2, 3, -4, -3, -2, -1, 0, 0, 0};
  int rd [10] = '{1, 4, 8, 4, -8, -12, -8, -4, -1, 0};
  int rs [10] = '{7, 21, 42, 7, -28, -63, -42, -21, -7, 0};

  initial begin
    // Reset held with a non-zero input
    repeat (3) begin
      @(posedge clk);
      #3;
      check("rst_hold_def", int'(y_def), 0);
      check("rst_hold_sat", int'(y_sat), 0);
    end
    rst_n = 1'b1;

    // Impulse
    step(1, 1, 7);
    step(0, 2, 7);
    step(0, 1, 7);
    step(0, 0, 0);
    step(0, 0, 0);

    // Ramp through the full signed input range
    for (int i = 0; i < 10; i++) begin
      step(rx[i], rd[i], rs[i]);
    end

    // Positive step from zero history
    step(3, 3, 21);
    step(3, 9, 42);
    step(3, 12, 63);
    step(3, 12, 63);

    // Negative step from clean history: default settles at -16, {7,7,7} clamps at -64
    reset_pulse();
    step(-4, -4, -28);
    step(-4, -12, -56);
    step(-4, -16, -64);
    step(-4, -16, -64);

    // Positive step straight after the negative one
    step(3, -9, -35);
    step(3, 5, 14);
    step(3, 12, 63);
    step(3, 12, 63);

    // Partial stream, then mid-stream reset must leave no residue
    step(1, 10, 49);
    step(2, 7, 42);
    step(3, 8, 42);
    reset_pulse();
    step(1, 1, 7);
    step(0, 2, 7);
    step(0, 1, 7);
    step(0, 0, 0);

    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fir_filter
`default_nettype wire
